// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared state encoding and statistics width for pipeline_stage
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [1:0] state_count(input state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_sat_cnt.sv
// ============================================================================
// pipeline_sat_cnt : up-counter that sticks at all-ones, cleared by rst_i only
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module pipeline_sat_cnt
  import pipeline_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_stage.sv
// ============================================================================
// pipeline_stage : two-entry skid-buffered valid/ready stage with flush.
// Optional stall/bubble statistics when PIPELINE_STAGE_STATS_EN is defined.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module pipeline_stage
  import pipeline_pkg::*;
#(
  parameter int PAYLOAD_W   = 128,
  parameter bit BUBBLE_ZERO = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o,
  input  logic                 flush_i,
  output logic [1:0]           count_o
`ifdef PIPELINE_STAGE_STATS_EN
  ,
  output logic [STAT_W-1:0]    stall_cnt_o,
  output logic [STAT_W-1:0]    bubble_cnt_o
`endif
);

  state_t               state_q;
  state_t               state_d;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] main_d;
  logic [PAYLOAD_W-1:0] skid_q;
  logic [PAYLOAD_W-1:0] skid_d;
  logic                 in_xfer;
  logic                 out_xfer;

  // Handshake outputs decode only the state register, so in_ready_o never
  // depends combinationally on out_ready_i.
  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = (state_q != TWO);
  assign count_o     = state_count(state_q);

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data_i;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data_i;
          end else if (in_xfer) begin
            state_d = TWO;
            skid_d  = in_data_i;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // main_q is left stale after a drain to EMPTY; gate it when required.
  generate
    if (BUBBLE_ZERO) begin : g_bubble_zero
      assign out_data_o = out_valid_o ? main_q : '0;
    end else begin : g_bubble_keep
      assign out_data_o = main_q;
    end
  endgenerate

`ifdef PIPELINE_STAGE_STATS_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = out_valid_o && !out_ready_i;
  assign bubble_inc = !out_valid_o && out_ready_i;

  pipeline_sat_cnt #(
    .W (STAT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  pipeline_sat_cnt #(
    .W (STAT_W)
  ) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stage.sv
// ============================================================================
// tb_pipeline_stage : directed + random checks of pipeline_stage against a
// queue-based reference model. Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stage;

  localparam int PW = 128;

  logic          clk;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [PW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [PW-1:0] out_data_o;
  logic          flush_i;
  logic [1:0]    count_o;
`ifdef PIPELINE_STAGE_STATS_EN
  logic [15:0]   stall_cnt_o;
  logic [15:0]   bubble_cnt_o;
`endif

  pipeline_stage #(
    .PAYLOAD_W   (PW),
    .BUBBLE_ZERO (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .flush_i     (flush_i),
    .count_o     (count_o)
`ifdef PIPELINE_STAGE_STATS_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: payloads held, in arrival order.
  logic [PW-1:0] model_q[$];
  int            stall_m  = 0;
  int            bubble_m = 0;

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [PW-1:0] exp_data;
    exp_data = (model_q.size() > 0) ? model_q[0] : '0;
    check_eq("out_valid", PW'(out_valid_o), PW'(model_q.size() > 0));
    check_eq("in_ready",  PW'(in_ready_o),  PW'(model_q.size() < 2));
    check_eq("count",     PW'(count_o),     PW'(model_q.size()));
    check_eq("out_data",  out_data_o,       exp_data);
`ifdef PIPELINE_STAGE_STATS_EN
    check_eq("stall_cnt",  PW'(stall_cnt_o),  PW'(stall_m));
    check_eq("bubble_cnt", PW'(bubble_cnt_o), PW'(bubble_m));
`endif
  endtask

  // Called at a negedge: check, drive, advance model, move to next negedge.
  task automatic step(input logic v, input logic [PW-1:0] d, input logic r,
                      input logic f, input logic rs);
    bit in_x;
    bit out_x;
    compare_outputs();
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    rst_i       = rs;
    if (rs) begin
      model_q.delete();
      stall_m  = 0;
      bubble_m = 0;
    end else begin
      if (model_q.size() > 0 && !r && stall_m < 65535) stall_m++;
      if (model_q.size() == 0 && r && bubble_m < 65535) bubble_m++;
      if (f) begin
        model_q.delete();
      end else begin
        in_x  = v && (model_q.size() < 2);
        out_x = r && (model_q.size() > 0);
        if (out_x) void'(model_q.pop_front());
        if (in_x) model_q.push_back(d);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [PW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    // Reset state
    check_eq("rst_out_valid", PW'(out_valid_o), '0);
    check_eq("rst_in_ready",  PW'(in_ready_o),  PW'(1));
    check_eq("rst_count",     PW'(count_o),     '0);
    check_eq("rst_out_data",  out_data_o,       '0);

    // Streaming 1..8 at full throughput
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, PW'(i), 1'b1, 1'b0, 1'b0);
      check_eq("stream_data",  out_data_o,   PW'(i));
      check_eq("stream_count", PW'(count_o), PW'(1));
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("stream_drain", PW'(out_valid_o), '0);

    // Back-pressure absorbs exactly two, then drains in order
    step(1'b1, PW'('hA), 1'b0, 1'b0, 1'b0);
    step(1'b1, PW'('hB), 1'b0, 1'b0, 1'b0);
    check_eq("bp_count",    PW'(count_o),    PW'(2));
    check_eq("bp_in_ready", PW'(in_ready_o), '0);
    check_eq("bp_head",     out_data_o,      PW'('hA));
    step(1'b1, PW'('hD), 1'b1, 1'b0, 1'b0);
    check_eq("bp_second",   out_data_o,      PW'('hB));
    check_eq("bp_ready_up", PW'(in_ready_o), PW'(1));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush in TWO discards held data and the payload offered that cycle
    step(1'b1, PW'('hA), 1'b0, 1'b0, 1'b0);
    step(1'b1, PW'('hB), 1'b0, 1'b0, 1'b0);
    step(1'b1, PW'('hC), 1'b0, 1'b1, 1'b0);
    check_eq("flush_valid", PW'(out_valid_o), '0);
    check_eq("flush_data",  out_data_o,       '0);
    check_eq("flush_ready", PW'(in_ready_o),  PW'(1));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_eq("flush_no_c", PW'(out_valid_o), '0);
    end

    // Flush coinciding with an output transfer
    step(1'b1, PW'('h11), 1'b0, 1'b0, 1'b0);
    step(1'b1, PW'('h22), 1'b1, 1'b1, 1'b0);
    check_eq("flush_out_count", PW'(count_o), '0);

    // Reset plus flush with held data mid-stream
    step(1'b1, PW'('h5), 1'b0, 1'b0, 1'b0);
    step(1'b1, PW'('h6), 1'b0, 1'b0, 1'b0);
    step(1'b1, PW'('h7), 1'b1, 1'b1, 1'b1);
    check_eq("rst_mid_valid", PW'(out_valid_o), '0);
    check_eq("rst_mid_ready", PW'(in_ready_o),  PW'(1));
    check_eq("rst_mid_count", PW'(count_o),     '0);
    check_eq("rst_mid_data",  out_data_o,       '0);
`ifdef PIPELINE_STAGE_STATS_EN
    check_eq("rst_mid_stall",  PW'(stall_cnt_o),  '0);
    check_eq("rst_mid_bubble", PW'(bubble_cnt_o), '0);
`endif

    // Randomized traffic with varying pressure, occasional flush and reset
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic v, r, f, rs;
        v  = ($urandom_range(3, 0) <= ph);
        r  = ($urandom_range(3, 0) >= ph);
        f  = ($urandom_range(19, 0) == 0);
        rs = ($urandom_range(89, 0) == 0);
        step(v, rand_data(), r, f, rs);
      end
    end

`ifdef PIPELINE_STAGE_STATS_EN
    // Long stall saturates the stall counter
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, rand_data(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("stall_sat",   PW'(stall_cnt_o),  PW'(16'hFFFF));
    check_eq("bubble_zero", PW'(bubble_cnt_o), '0);
`endif

    compare_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_stage.md
PIPELINE_STAGE -- requirements
Module: pipeline_stage

Interface
REQ-001 SHALL provide parameter PAYLOAD_W, default 128, width of the stage payload (bundled control + data fields).
REQ-002 SHALL provide parameter BUBBLE_ZERO, default 1; when 1, out_data_o reads all-zero whenever out_valid_o=0.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid_i  input  1  upstream payload valid.
REQ-006 SHALL have port in_ready_o  output  1  stage can accept; registered, no combinational path from out_ready_i.
REQ-007 SHALL have port in_data_i  input  PAYLOAD_W  upstream payload.
REQ-008 SHALL have port out_valid_o  output  1  downstream payload valid.
REQ-009 SHALL have port out_ready_i  input  1  downstream accepts.
REQ-010 SHALL have port out_data_o  output  PAYLOAD_W  downstream payload.
REQ-011 SHALL have port flush_i  input  1  discard all held payloads (branch/hazard bubble).
REQ-012 SHALL have port count_o  output  2  entries held (0..2).

Function
REQ-013 SHALL count an input transfer when in_valid_i && in_ready_o, and an output transfer when out_valid_o && out_ready_i, sampled at the same edge.
REQ-014 SHALL hold a main register (drives out_data_o) and one skid register; states EMPTY, ONE, TWO; count_o = 0/1/2 respectively.
REQ-015 EMPTY: input transfer -> ONE, main<=in_data_i; else stay.
REQ-016 ONE: in+out -> ONE, main<=in_data_i; in only -> TWO, skid<=in_data_i; out only -> EMPTY; neither -> stay.
REQ-017 TWO: out transfer -> ONE, main<=skid; else stay; no input transfer possible.
REQ-018 SHALL drive out_valid_o=1 in ONE and TWO, 0 in EMPTY; in_ready_o=1 in EMPTY and ONE, 0 in TWO.
REQ-019 Latency: payload accepted at edge N is visible on out_data_o with out_valid_o=1 after edge N when the stage was EMPTY (one cycle).
REQ-020 SHALL preserve order strictly; no payload duplicated or dropped except by flush_i or rst_i.
REQ-021 flush_i=1 SHALL force EMPTY, zero main and skid, and discard any input offered that cycle; in_ready_o=1 and out_valid_o=0 after the edge.
REQ-022 Simultaneous flush_i and output transfer: the output transfer counts as completed; stage still ends EMPTY.
REQ-023 Full throughput: with out_ready_i=1 constantly, one payload per cycle SHALL pass, state remaining ONE.
REQ-024 Back-pressure: out_ready_i=0 while ONE SHALL absorb exactly one more payload (TWO), then deassert in_ready_o.

Reset
REQ-025 rst_i=1 at an edge SHALL force EMPTY, main=0, skid=0, out_valid_o=0, in_ready_o=1, count_o=0; rst_i overrides flush_i and all transfers.
REQ-026 Reset mid-operation SHALL discard held payloads with no output transfer counted that cycle.

Configuration
REQ-027 Macro PIPELINE_STAGE_STATS_EN defined SHALL add outputs stall_cnt_o (16) and bubble_cnt_o (16).
REQ-028 stall_cnt_o SHALL increment each cycle out_valid_o && !out_ready_i; bubble_cnt_o each cycle !out_valid_o && out_ready_i; both saturate at 16'hFFFF, clear only on rst_i (not flush_i).
REQ-029 Macro undefined SHALL omit both ports and counter logic; all other behaviour identical.

Structure
REQ-030 Package pipeline_pkg SHALL hold the state typedef (EMPTY/ONE/TWO) and constant STAT_W=16.
REQ-031 Saturating counter SHALL be sub-module pipeline_sat_cnt, instantiated twice only under PIPELINE_STAGE_STATS_EN.

Verification
REQ-032 Stream 0x1..0x8 with out_ready_i=1 -> outputs 0x1..0x8 on 8 consecutive cycles, first one cycle after first accept, count_o=1 throughout.
REQ-033 Accept 0xA, 0xB with out_ready_i=0 -> count_o=2, in_ready_o=0; raise out_ready_i -> 0xA then 0xB, in_ready_o=1 after first drain.
REQ-034 In TWO (0xA,0xB) assert flush_i with in_valid_i=1, in_data_i=0xC -> next cycle EMPTY, out_valid_o=0, out_data_o=0, 0xC never appears.
REQ-035 rst_i and flush_i asserted with held data mid-stream -> all outputs at reset values after one edge; stats counters (if enabled) zero.
REQ-036 With PIPELINE_STAGE_STATS_EN: hold out_valid_o=1, out_ready_i=0 for 70000 cycles -> stall_cnt_o=16'hFFFF, bubble_cnt_o=0.
